crypt_uart_loader: RTL and testbench
====================================

# crypt_uart_loader

- Receives a UART byte stream from the board's serial pin and decodes a two-byte command protocol.
- Holds the resulting key, data byte and mode select in registers that drive the combinational 8-bit encrypt/decrypt core directly.
- Sits immediately upstream of that core, replacing the 17 static switch inputs with a serially loaded, registered front end.

## Interface
Parameters:
- CLKS_PER_BIT, default 104: clock cycles per UART bit (12 MHz / 115200 baud). Legal range 8 to 65535.

Ports:
- clk  input  1  system clock. One clock domain; reset is synchronous and active-high.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous UART line. Idle high, 8 data bits, LSB first, 1 stop bit.
- key  output  8  key byte to the core. Reset 8'h00.
- inp  output  8  data byte to the core. Reset 8'h00.
- sel  output  1  mode to the core: 1 = encrypt, 0 = decrypt. Reset 0.
- valid  output  1  one-cycle pulse when inp/sel have been reloaded. Reset 0.
- busy  output  1  high while a UART frame is being received (states other than IDLE). Reset 0.
- err  output  1  one-cycle pulse on any framing, parity or protocol error. Reset 0.

## Operation
Receiver
- rx passes through a 2-flop synchronizer; rxs is the synchronized value. Its reset value is 1.
- The receiver FSM has these states:
  - IDLE: rxs==0 goes to START and clears the bit-time counter.
  - START: at count CLKS_PER_BIT/2 (integer division), sample rxs.
    - If 0: go to DATA.
    - If 1: treat as a glitch and return to IDLE with no err.
  - DATA: sample every CLKS_PER_BIT cycles and shift into bit[0]..bit[7]. After 8 samples go to STOP, or to PARITY when compiled in.
  - STOP: sample once at the bit centre.
    - 1: byte_done. Pulse internally for one cycle, then go to IDLE.
    - 0: framing error. Pulse err, discard the byte, go to WAIT_HI.
  - WAIT_HI: stay until rxs==1, then go to IDLE. This prevents a held-low line from re-triggering START.

Command parser (runs on byte_done)
- CMD state: the byte is a command.
  - 8'h4B 'K', 8'h45 'E' and 8'h44 'D' are latched as the pending command; parser goes to ARG.
  - Any other byte pulses err and the parser stays in CMD.
- ARG state: the byte is the operand.
  - 'K' loads key and does not pulse valid.
  - 'E' loads inp, sets sel=1 and pulses valid.
  - 'D' loads inp, sets sel=0 and pulses valid.
  - The parser then returns to CMD.
- A framing or parity error while in ARG returns the parser to CMD. No register changes.
- key, inp and sel change only on a successful ARG byte. They hold otherwise, so the downstream core output is stable between loads.
- rst at any cycle has these effects:
  - Aborts any frame in progress.
  - Returns both FSMs to IDLE/CMD.
  - Drives all outputs to their reset values on the next edge.
  - The synchronizer resets to 1, so no false start is detected.

## Timing
- Start detection happens 2 cycles after the rx falling edge, due to the synchronizer.
- The stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after entering START.
  - Add CLKS_PER_BIT when parity is compiled in.
- byte_done and the stop sample fall in the same cycle.
- key, inp, sel, valid and err update on the edge following byte_done, giving 1-cycle register latency.
- valid and err are exactly one cycle wide and never assert in the same cycle.
- busy rises on the edge entering START. It falls on the edge leaving STOP, or on leaving WAIT_HI.
- Back-to-back frames are accepted: a start bit arriving immediately after the stop-bit centre is detected normally.

## Configuration
- Macro CRYPT_UART_LOADER_PARITY_EN.
  - Defined: each frame carries an even parity bit after bit 7, sampled in a PARITY state.
    - On mismatch, the byte is discarded, err pulses, and the FSM goes to STOP, then IDLE.
    - A parity failure in ARG returns the parser to CMD.
  - Undefined: there is no PARITY state and frames are 8N1.

## Test plan
- Reset, then idle rx=1 for 1000 cycles: key=00, inp=00, sel=0, valid=0, err=0, busy=0 throughout.
- Send 'K',0x3C then 'E',0xA5: key=3C with no valid. Then inp=A5, sel=1, and valid pulses once, one cycle after the second stop-bit centre.
- Send 'D',0x5A back-to-back with no idle gap: inp=5A, sel=0, one valid pulse, key unchanged at 3C.
- Send byte 0x41: err pulses once, outputs unchanged, and the following 'E',0x01 loads normally.
- Send 'E', then a frame with stop bit held 0 for 3 bit times: err pulses once, busy stays high until rx returns high, parser is back in CMD, inp unchanged.
- Send a 0.3-bit low glitch on rx, then assert rst mid-frame of 'K': no err, no load, and all outputs at reset values after the rst edge.

Source files
------------

// File: rtl/crypt_uart_loader.sv
// UART-loaded key/data/mode registers feeding the 8-bit crypt core.
// Optional even parity: define CRYPT_UART_LOADER_PARITY_EN (default 8N1).
module crypt_uart_loader #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] key,
  output logic [7:0] inp,
  output logic       sel,
  output logic       valid,
  output logic       busy,
  output logic       err
);

  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [7:0] CMD_K = 8'h4B;
  localparam logic [7:0] CMD_E = 8'h45;
  localparam logic [7:0] CMD_D = 8'h44;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
`ifdef CRYPT_UART_LOADER_PARITY_EN
    S_WAIT_HI = 3'd4,
    S_PARITY  = 3'd5
`else
    S_WAIT_HI = 3'd4
`endif
  } rx_state_e;

  typedef enum logic {
    P_CMD = 1'b0,
    P_ARG = 1'b1
  } ps_state_e;

  logic        rx_m_q;
  logic        rxs_q;
  rx_state_e   st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        perr_q, perr_d;
  logic        byte_done;
  logic        rx_err;

  ps_state_e   ps_q, ps_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  key_q, key_d;
  logic [7:0]  inp_q, inp_d;
  logic        sel_q, sel_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // Two-flop synchronizer; resets to idle-high so no false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rxs_q  <= rx_m_q;
    end
  end

  // Receiver next-state: bit timing, shifting, frame checks.
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q + 16'd1;
    bit_d     = bit_q;
    sh_d      = sh_q;
    perr_d    = perr_q;
    byte_done = 1'b0;
    rx_err    = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        cnt_d  = 16'd0;
        perr_d = 1'b0;
        if (!rxs_q) st_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d = 16'd0;
          bit_d = 3'd0;
          st_d  = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = 16'd0;
          sh_d  = {rxs_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef CRYPT_UART_LOADER_PARITY_EN
            st_d = S_PARITY;
`else
            st_d = S_STOP;
`endif
          end
        end
      end
`ifdef CRYPT_UART_LOADER_PARITY_EN
      S_PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d = 16'd0;
          st_d  = S_STOP;
          if ((^sh_q) ^ rxs_q) begin
            rx_err = 1'b1;
            perr_d = 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = 16'd0;
          if (rxs_q) begin
            st_d      = S_IDLE;
            byte_done = !perr_q;
          end else begin
            st_d   = S_WAIT_HI;
            rx_err = !perr_q;
          end
        end
      end
      S_WAIT_HI: begin
        cnt_d = 16'd0;
        if (rxs_q) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      cnt_q  <= 16'd0;
      bit_q  <= 3'd0;
      sh_q   <= 8'h00;
      perr_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      perr_q <= perr_d;
    end
  end

  // Command parser: command byte then operand byte.
  always_comb begin
    ps_d    = ps_q;
    cmd_d   = cmd_q;
    key_d   = key_q;
    inp_d   = inp_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (byte_done) begin
      unique case (ps_q)
        P_CMD: begin
          if (sh_q == CMD_K || sh_q == CMD_E || sh_q == CMD_D) begin
            cmd_d = sh_q;
            ps_d  = P_ARG;
          end else begin
            err_d = 1'b1;
          end
        end
        P_ARG: begin
          ps_d = P_CMD;
          unique case (1'b1)
            cmd_q == CMD_K: key_d = sh_q;
            cmd_q == CMD_E: begin
              inp_d   = sh_q;
              sel_d   = 1'b1;
              valid_d = 1'b1;
            end
            cmd_q == CMD_D: begin
              inp_d   = sh_q;
              sel_d   = 1'b0;
              valid_d = 1'b1;
            end
            default: ;
          endcase
        end
        default: ps_d = P_CMD;
      endcase
    end else if (rx_err) begin
      err_d = 1'b1;
      ps_d  = P_CMD;
    end
  end

  // Parser state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q    <= P_CMD;
      cmd_q   <= 8'h00;
      key_q   <= 8'h00;
      inp_q   <= 8'h00;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      cmd_q   <= cmd_d;
      key_q   <= key_d;
      inp_q   <= inp_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign key   = key_q;
  assign inp   = inp_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = (st_q != S_IDLE);

endmodule

// File: tb/tb_crypt_uart_loader.sv
// Self-checking bench for crypt_uart_loader.
// Byte-level reference model of the K/E/D command protocol.
module tb_crypt_uart_loader;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef CRYPT_UART_LOADER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] key, inp;
  logic       sel, valid, busy, err;

  crypt_uart_loader #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .key(key), .inp(inp), .sel(sel),
    .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int nvalid = 0;
  int nerr = 0;
  int last_valid_cyc = -1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      nvalid++;
      last_valid_cyc = cyc;
    end
    if (err === 1'b1) nerr++;
    if (valid === 1'b1 || err === 1'b1) begin
      checks++;
      if (valid === 1'b1 && err === 1'b1) begin
        failures++;
        $display("FAIL valid_err_overlap cyc=%0d got both=1 exp not both", cyc);
      end
    end
  end

  // Reference model
  logic [7:0] m_key, m_inp, m_cmd;
  logic       m_sel, m_arg;
  int         exp_valid, exp_err;

  function automatic void model_reset();
    m_key = 8'h00; m_inp = 8'h00; m_cmd = 8'h00;
    m_sel = 1'b0; m_arg = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (!m_arg) begin
      if (b == 8'h4B || b == 8'h45 || b == 8'h44) begin
        m_cmd = b;
        m_arg = 1'b1;
      end else begin
        exp_err++;
      end
    end else begin
      m_arg = 1'b0;
      if (m_cmd == 8'h4B) m_key = b;
      else begin
        m_inp = b;
        m_sel = (m_cmd == 8'h45);
        exp_valid++;
      end
    end
  endfunction

  function automatic void model_bad_frame();
    exp_err++;
    m_arg = 1'b0;
  endfunction

  task automatic bit_time(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int stop_bits, output int t0);
    t0 = cyc;
    bit_time(1'b0, C);
    for (int i = 0; i < 8; i++) bit_time(b[i], C);
    if (PB == 1) bit_time(^b, C);
    bit_time(stop_v, C * stop_bits);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (key !== 8'h00 || inp !== 8'h00 || sel !== 1'b0 ||
          valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) bad++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_idle bad_cycles got=%0d exp=0", bad);
    end
    checks++;
    if ({key, inp, sel, busy} !== 18'h0) begin
      failures++;
      $display("FAIL reset_vals got=%h exp=0", {key, inp, sel, busy});
    end
  endtask

  task automatic test_load();
    int v0, e0, t0, exp_t;
    v0 = nvalid; e0 = nerr;
    send_frame(8'h4B, 1'b1, 1, t0); model_byte(8'h4B);
    send_frame(8'h3C, 1'b1, 1, t0); model_byte(8'h3C);
    checks++;
    if (key !== 8'h3C || nvalid - v0 !== 0) begin
      failures++;
      $display("FAIL load_key key got=%h exp=3c valids got=%0d exp=0",
               key, nvalid - v0);
    end
    send_frame(8'h45, 1'b1, 1, t0); model_byte(8'h45);
    send_frame(8'hA5, 1'b1, 1, t0); model_byte(8'hA5);
    exp_t = t0 + 4 + H + (9 + PB) * C;
    checks++;
    if (inp !== 8'hA5 || sel !== 1'b1) begin
      failures++;
      $display("FAIL load_enc inp/sel got=%h/%b exp=a5/1", inp, sel);
    end
    checks++;
    if (nvalid - v0 !== 1 || nerr - e0 !== 0) begin
      failures++;
      $display("FAIL load_enc_pulses valid got=%0d exp=1 err got=%0d exp=0",
               nvalid - v0, nerr - e0);
    end
    checks++;
    if (last_valid_cyc !== exp_t) begin
      failures++;
      $display("FAIL valid_timing got=%0d exp=%0d", last_valid_cyc, exp_t);
    end
  endtask

  task automatic test_back_to_back();
    int v0, t0;
    v0 = nvalid;
    send_frame(8'h44, 1'b1, 1, t0); model_byte(8'h44);
    send_frame(8'h5A, 1'b1, 1, t0); model_byte(8'h5A);
    checks++;
    if (inp !== 8'h5A || sel !== 1'b0 || key !== 8'h3C) begin
      failures++;
      $display("FAIL b2b_dec inp/sel/key got=%h/%b/%h exp=5a/0/3c",
               inp, sel, key);
    end
    checks++;
    if (nvalid - v0 !== 1) begin
      failures++;
      $display("FAIL b2b_valid got=%0d exp=1", nvalid - v0);
    end
  endtask

  task automatic test_bad_cmd();
    int v0, e0, t0;
    v0 = nvalid; e0 = nerr;
    send_frame(8'h41, 1'b1, 1, t0); model_byte(8'h41);
    checks++;
    if (nerr - e0 !== 1 || nvalid - v0 !== 0 ||
        inp !== 8'h5A || key !== 8'h3C || sel !== 1'b0) begin
      failures++;
      $display("FAIL bad_cmd err got=%0d exp=1 inp=%h key=%h sel=%b",
               nerr - e0, inp, key, sel);
    end
    bit_time(1'b1, C);
    send_frame(8'h45, 1'b1, 1, t0); model_byte(8'h45);
    send_frame(8'h01, 1'b1, 1, t0); model_byte(8'h01);
    checks++;
    if (inp !== 8'h01 || sel !== 1'b1 || nvalid - v0 !== 1) begin
      failures++;
      $display("FAIL after_bad_cmd inp/sel got=%h/%b exp=01/1 valid=%0d",
               inp, sel, nvalid - v0);
    end
  endtask

  task automatic test_framing();
    int v0, e0, t0;
    v0 = nvalid; e0 = nerr;
    send_frame(8'h45, 1'b1, 1, t0); model_byte(8'h45);
    send_frame(8'h99, 1'b0, 3, t0); model_bad_frame();
    checks++;
    if (busy !== 1'b1 || nerr - e0 !== 1) begin
      failures++;
      $display("FAIL frame_err busy got=%b exp=1 err got=%0d exp=1",
               busy, nerr - e0);
    end
    bit_time(1'b1, 4);
    checks++;
    if (busy !== 1'b0 || inp !== 8'h01 || nvalid - v0 !== 0) begin
      failures++;
      $display("FAIL frame_recover busy=%b inp got=%h exp=01 valid=%0d",
               busy, inp, nvalid - v0);
    end
    bit_time(1'b1, C);
    send_frame(8'h4B, 1'b1, 1, t0); model_byte(8'h4B);
    send_frame(8'h11, 1'b1, 1, t0); model_byte(8'h11);
    checks++;
    if (key !== 8'h11 || inp !== 8'h01 || nvalid - v0 !== 0) begin
      failures++;
      $display("FAIL parser_cmd key got=%h exp=11 inp=%h valid=%0d",
               key, inp, nvalid - v0);
    end
  endtask

  task automatic test_glitch_reset();
    int v0, e0;
    logic [7:0] b;
    v0 = nvalid; e0 = nerr;
    bit_time(1'b0, (C * 3) / 10);
    bit_time(1'b1, 2 * C);
    checks++;
    if (nerr - e0 !== 0 || busy !== 1'b0 || key !== m_key || inp !== m_inp) begin
      failures++;
      $display("FAIL glitch err got=%0d exp=0 busy=%b key=%h inp=%h",
               nerr - e0, busy, key, inp);
    end
    b = 8'h4B;
    bit_time(1'b0, C);
    for (int i = 0; i < 4; i++) bit_time(b[i], C);
    rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if ({key, inp, sel, valid, err, busy} !== 20'h0) begin
      failures++;
      $display("FAIL mid_rst got=%h exp=0", {key, inp, sel, valid, err, busy});
    end
    bit_time(1'b1, 12 * C);
    checks++;
    if (nerr - e0 !== 0 || nvalid - v0 !== 0 || key !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_rst err=%0d valid=%0d key=%h busy=%b exp 0",
               nerr - e0, nvalid - v0, key, busy);
    end
  endtask

  task automatic test_random();
    int v0, e0, t0, kind, gap;
    logic [7:0] b;
    logic [7:0] cmds [3];
    cmds[0] = 8'h4B; cmds[1] = 8'h45; cmds[2] = 8'h44;
    for (int n = 0; n < 30; n++) begin
      v0 = nvalid; e0 = nerr;
      exp_valid = 0; exp_err = 0;
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        b = 8'($urandom);
        send_frame(b, 1'b1, 1, t0); model_byte(b);
      end else if (kind == 1) begin
        b = 8'($urandom);
        send_frame(b, 1'b0, 1, t0); model_bad_frame();
      end else begin
        b = cmds[$urandom_range(0, 2)];
        send_frame(b, 1'b1, 1, t0); model_byte(b);
        b = 8'($urandom);
        send_frame(b, 1'b1, 1, t0); model_byte(b);
      end
      gap = $urandom_range(0, C);
      if (kind == 1) gap = gap + 3;
      if (gap > 0) bit_time(1'b1, gap);
      checks++;
      if (key !== m_key || inp !== m_inp || sel !== m_sel) begin
        failures++;
        $display("FAIL rand_regs n=%0d got=%h/%h/%b exp=%h/%h/%b",
                 n, key, inp, sel, m_key, m_inp, m_sel);
      end
      checks++;
      if (nvalid - v0 !== exp_valid || nerr - e0 !== exp_err) begin
        failures++;
        $display("FAIL rand_pulses n=%0d valid got=%0d exp=%0d err got=%0d exp=%0d",
                 n, nvalid - v0, exp_valid, nerr - e0, exp_err);
      end
    end
  endtask

  initial begin
    exp_valid = 0;
    exp_err = 0;
    model_reset();
    test_reset();
    test_load();
    test_back_to_back();
    test_bad_cmd();
    test_framing();
    test_glitch_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
